// File: rtl/calc_alu_if.sv
// Operand, strobe and result bundle between the calculator FSM and calc_alu.
interface calc_alu_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ALU_SET;
  logic [1:0]       ALU_MODE;
  logic             ALU_READ;
  logic [WIDTH-1:0] OUT_DATA;
  logic             BUSY;
  logic             VALID;
  logic             OVERFLOW;

  modport master (
    output A, B, ALU_SET, ALU_MODE, ALU_READ,
    input  OUT_DATA, BUSY, VALID, OVERFLOW
  );

  modport slave (
    input  A, B, ALU_SET, ALU_MODE, ALU_READ,
    output OUT_DATA, BUSY, VALID, OVERFLOW
  );
endinterface

// File: rtl/calc_alu.sv
// Multi-cycle calculator ALU: 1-cycle add/sub, shift-add multiply and repeated-multiply exponent.
// Optional macro ALU_SAT_EN: overflowed results saturate instead of wrapping.
module calc_alu #(
  parameter int unsigned WIDTH = 5
) (
  input logic      CLOCK,
  input logic      RESET,
  calc_alu_if.slave alu
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_EXP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               set_q;
  logic               arm_q, arm_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic [PW-1:0]      prod_nx_c;
  logic [WIDTH-1:0]   prod_lo_c;
  logic               prod_hi_c;
  logic               step_last_c;
  logic               start_c;
  logic               fin_c;
  logic               fin_ovf_c;

  assign sum_c       = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c      = {1'b0, a_q} - {1'b0, b_q};
  assign prod_nx_c   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_lo_c   = prod_nx_c[WIDTH-1:0];
  assign prod_hi_c   = |prod_nx_c[PW-1:WIDTH];
  assign step_last_c = (bit_q == CNT_W'(WIDTH - 1));
  // arm_q blocks a start until ALU_SET has been seen low since reset.
  assign start_c     = alu.ALU_SET && !set_q && arm_q;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q | ~alu.ALU_SET;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    bit_d     = bit_q;
    exp_d     = exp_q;
    res_d     = res_q;
    acc_ovf_d = acc_ovf_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    valid_d   = 1'b0;
    fin_c     = 1'b0;
    fin_ovf_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d   = CALC;
          busy_d    = 1'b1;
          mode_d    = alu.ALU_MODE;
          a_d       = alu.A;
          b_d       = alu.B;
          mcand_d   = PW'(alu.A);
          mplier_d  = (alu.ALU_MODE == MODE_EXP) ? WIDTH'(1) : alu.B;
          prod_d    = '0;
          bit_d     = '0;
          exp_d     = alu.B;
          res_d     = WIDTH'(1);
          acc_ovf_d = 1'b0;
          ovf_d     = 1'b0;
        end
      end

      CALC: begin
        if (!alu.ALU_SET) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          case (mode_q)
            MODE_ADD: begin
              fin_c     = 1'b1;
              fin_ovf_c = sum_c[WIDTH];
              res_d     = sum_c[WIDTH-1:0];
`ifdef ALU_SAT_EN
              if (sum_c[WIDTH]) res_d = '1;
`endif
            end
            MODE_SUB: begin
              fin_c     = 1'b1;
              fin_ovf_c = diff_c[WIDTH];
              res_d     = diff_c[WIDTH-1:0];
`ifdef ALU_SAT_EN
              if (diff_c[WIDTH]) res_d = '0;
`endif
            end
            MODE_MUL: begin
              prod_d   = prod_nx_c;
              mcand_d  = mcand_q << 1;
              mplier_d = mplier_q >> 1;
              bit_d    = bit_q + CNT_W'(1);
              if (step_last_c) begin
                fin_c     = 1'b1;
                fin_ovf_c = prod_hi_c;
                res_d     = prod_lo_c;
`ifdef ALU_SAT_EN
                if (prod_hi_c) res_d = '1;
`endif
              end
            end
            default: begin
              // Exponent: each completed multiply reloads the multiplier with the truncated acc.
              if (exp_q == '0) begin
                fin_c = 1'b1;
              end else begin
                prod_d   = prod_nx_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                bit_d    = bit_q + CNT_W'(1);
                if (step_last_c) begin
                  exp_d     = exp_q - WIDTH'(1);
                  bit_d     = '0;
                  prod_d    = '0;
                  mcand_d   = PW'(a_q);
                  mplier_d  = prod_lo_c;
                  res_d     = prod_lo_c;
                  acc_ovf_d = acc_ovf_q | prod_hi_c;
                  fin_ovf_c = acc_ovf_q | prod_hi_c;
                  if (exp_q == WIDTH'(1)) fin_c = 1'b1;
`ifdef ALU_SAT_EN
                  if (prod_hi_c) begin
                    res_d = '1;
                    fin_c = 1'b1;
                  end
`endif
                end
              end
            end
          endcase
        end
      end

      DONE: begin
        valid_d = 1'b1;
        if (!alu.ALU_SET) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin_c) begin
      state_d = DONE;
      busy_d  = 1'b0;
      valid_d = 1'b1;
      ovf_d   = fin_ovf_c;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      set_q     <= 1'b0;
      arm_q     <= 1'b0;
      mode_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      bit_q     <= '0;
      exp_q     <= '0;
      res_q     <= '0;
      acc_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= alu.ALU_SET;
      arm_q     <= arm_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      bit_q     <= bit_d;
      exp_q     <= exp_d;
      res_q     <= res_d;
      acc_ovf_q <= acc_ovf_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  // Result reaches the shared bus only while the FSM is reading a valid result.
  assign alu.OUT_DATA = (valid_q && alu.ALU_READ) ? res_q : '0;
  assign alu.BUSY     = busy_q;
  assign alu.VALID    = valid_q;
  assign alu.OVERFLOW = ovf_q;

endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: stimulus queues expected results, a monitor checks each VALID rise.
module tb_calc_alu;

  localparam int unsigned W = 5;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int d;
    int o;
    int lat;
    int t0;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic valid_prev;

  calc_alu_if #(.WIDTH(W)) bus ();

  calc_alu #(.WIDTH(W)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .alu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per VALID rise and checks data, overflow and latency.
  always @(negedge clk) begin
    if (rst_n && bus.VALID && !valid_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, int'(bus.OUT_DATA), e.d);
        chk({e.name, "_ovf"}, int'(bus.OVERFLOW), e.o);
        chk({e.name, "_lat"}, cyc - e.t0, e.lat);
      end
    end
    valid_prev <= rst_n ? bus.VALID : 1'b0;
  end

  task automatic run_op(input string name, input int a, input int b, input int mode,
                        input int ed, input int eo, input int lat, input bit scramble);
    exp_t e;
    bit   seen;
    @(negedge clk);
    #2;
    bus.A        = W'(a);
    bus.B        = W'(b);
    bus.ALU_MODE = 2'(mode);
    bus.ALU_SET  = 1'b1;
    e.d = ed; e.o = eo; e.lat = lat; e.t0 = cyc; e.name = name;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (scramble && i == 1) begin
        #2;
        bus.A        = W'(31);
        bus.B        = W'(1);
        bus.ALU_MODE = 2'b00;
      end
      if (bus.VALID) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    #2;
    bus.ALU_READ = 1'b0;
    #1 chk({name, "_noread"}, int'(bus.OUT_DATA), 0);
    bus.ALU_READ = 1'b1;
    #1 chk({name, "_reread"}, int'(bus.OUT_DATA), ed);
    @(negedge clk);
    chk({name, "_held"}, int'(bus.VALID), 1);
    #2 bus.ALU_SET = 1'b0;
    @(negedge clk);
    chk({name, "_vdrop"}, int'(bus.VALID), 0);
    chk({name, "_odrop"}, int'(bus.OVERFLOW), 0);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; valid_prev = 1'b0;
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALU_MODE = '0; bus.ALU_SET = 1'b0; bus.ALU_READ = 1'b1;
    #1;
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_valid", int'(bus.VALID), 0);
    chk("rst_data", int'(bus.OUT_DATA), 0);
    chk("rst_ovf", int'(bus.OVERFLOW), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_12_9",  12,  9, 0, 21, 0, 2, 1'b0);
    run_op("sub_3_5",    3,  5, 1, SAT ? 0 : 30, 1, 2, 1'b0);
    run_op("sub_9_4",    9,  4, 1, 5, 0, 2, 1'b0);
    run_op("add_20_15", 20, 15, 0, SAT ? 31 : 3, 1, 2, 1'b0);
    run_op("add_31_1",  31,  1, 0, SAT ? 31 : 0, 1, 2, 1'b0);
    run_op("mul_6_5",    6,  5, 2, 30, 0, 6, 1'b0);
    run_op("mul_7_7",    7,  7, 2, SAT ? 31 : 17, 1, 6, 1'b0);
    run_op("mul_31_31", 31, 31, 2, SAT ? 31 : 1, 1, 6, 1'b0);
    run_op("mul_scr",    6,  5, 2, 30, 0, 6, 1'b1);
    run_op("exp_2_3",    2,  3, 3, 8, 0, 16, 1'b0);
    run_op("exp_3_4",    3,  4, 3, SAT ? 31 : 17, 1, 21, 1'b0);
    run_op("exp_2_5",    2,  5, 3, SAT ? 31 : 0, 1, 26, 1'b0);
    run_op("exp_5_2",    5,  2, 3, 25, 0, 11, 1'b0);
    run_op("exp_0_0",    0,  0, 3, 1, 0, 2, 1'b0);

    // Abort a multiply after three edges: no VALID may follow.
    @(negedge clk);
    #2;
    bus.A = W'(6); bus.B = W'(5); bus.ALU_MODE = 2'b10; bus.ALU_SET = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", int'(bus.BUSY), 1);
    #2 bus.ALU_SET = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.BUSY), 0);
    repeat (8) @(negedge clk);
    chk("abort_valid", int'(bus.VALID), 0);
    run_op("mul_4_3",    4,  3, 2, 12, 0, 6, 1'b0);

    // Reset in the middle of an exponent, with ALU_SET held high across release.
    @(negedge clk);
    #2;
    bus.A = W'(3); bus.B = W'(4); bus.ALU_MODE = 2'b11; bus.ALU_SET = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy", int'(bus.BUSY), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(bus.BUSY), 0);
    chk("mrst_valid", int'(bus.VALID), 0);
    chk("mrst_data", int'(bus.OUT_DATA), 0);
    chk("mrst_ovf", int'(bus.OVERFLOW), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_set_busy", int'(bus.BUSY), 0);
    chk("held_set_valid", int'(bus.VALID), 0);
    #2 bus.ALU_SET = 1'b0;
    @(negedge clk);
    run_op("add_post",   7,  8, 0, 15, 0, 2, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
